apb_cmd_queue: RTL and testbench

Command queue and issue sequencer that sits directly upstream of apb_top and drives its driver-side request interface (transfer, READ_WRITE, in_addr, in_wr_data).
- Buffers requester commands in a FIFO.
- Issues them one at a time, holding each until completion.
- Returns read data through a valid/ready response port.
- Decouples bursty software/bus-model traffic from the one-transfer-at-a-time APB leader.

---
 rtl/apb_cmd_queue_if.sv | 45 ++++
 rtl/apb_cmd_queue.sv | 182 ++++++++++++++++++
 tb/tb_apb_cmd_queue.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_queue_if.sv
// Requester, APB-driver and response signals of apb_cmd_queue grouped into one bundle.
// slave = the queue itself, master = the requester/integration side driving it.
interface apb_cmd_queue_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_wr_data;
    logic [DATA_WIDTH-1:0] out_rd_data;
    logic                  xfer_done;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  err_timeout;
    logic                  busy;
    logic [LEVEL_W-1:0]    level;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  out_rd_data, xfer_done, rsp_ready,
        output cmd_ready, transfer, READ_WRITE, in_addr, in_wr_data,
        output rsp_valid, rsp_data, rsp_err, err_timeout, busy, level
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output out_rd_data, xfer_done, rsp_ready,
        input  cmd_ready, transfer, READ_WRITE, in_addr, in_wr_data,
        input  rsp_valid, rsp_data, rsp_err, err_timeout, busy, level
    );
endinterface

// File: rtl/apb_cmd_queue.sv
// Command FIFO plus one-at-a-time issue sequencer feeding apb_top's driver-side request port.
// Optional WAIT-phase abort is enabled by defining APB_CMD_QUEUE_TIMEOUT_EN.
module apb_cmd_queue #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 32
) (
    input logic            PCLK,
    input logic            PRESET,
    apb_cmd_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("apb_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CAPTURE} state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_e                state_q, state_d;
    cmd_t                  mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_d;
    logic                  err_timeout_d;

    logic full, empty, push, pop, rsp_take, abort;
    cmd_t head;

    assign full     = (count_q == LVL_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.cmd_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign rsp_take = rsp_valid_q && bus.rsp_ready;
    // A read may only leave the FIFO once the single response slot is free (or freeing now).
    assign pop      = (state_q == ST_IDLE) && !empty && (head.write || !rsp_valid_q || rsp_take);

`ifdef APB_CMD_QUEUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, err_timeout_q;

    // xfer_done on the limit cycle takes priority over the abort.
    assign abort = (state_q == ST_WAIT) && !bus.xfer_done && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_ISSUE)     tmo_cnt_d = '0;
        else if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_q     <= '0;
            rsp_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_err_q     <= rsp_err_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.rsp_err     = rsp_err_q;
    assign bus.err_timeout = err_timeout_q;
`else
    assign abort           = 1'b0;
    assign bus.rsp_err     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // so clearing the entries would only cost reset routing.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= '{bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end

    // NOTE: every always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (pop) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.xfer_done) state_d = rw_q ? ST_IDLE : ST_CAPTURE;
                else if (abort)    state_d = ST_IDLE;
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = bus.rsp_err;
        err_timeout_d = abort;

        unique case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            rw_d    = head.write;
            addr_d  = head.addr;
            wdata_d = head.wdata;
        end

        if (rsp_take) rsp_valid_d = 1'b0;
        if (state_q == ST_CAPTURE) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.out_rd_data;
            rsp_err_d   = 1'b0;
        end else if (abort && !rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
        end
    end

    always_comb begin
        bus.transfer = (state_q == ST_ISSUE);
        bus.busy     = (state_q != ST_IDLE) || !empty;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.READ_WRITE = rw_q;
    assign bus.in_addr    = addr_q;
    assign bus.in_wr_data = wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.level      = count_q;
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: reset, write/read issue timing, full FIFO and wrap,
// response back-pressure, and the WAIT timeout when APB_CMD_QUEUE_TIMEOUT_EN is defined.
module tb_apb_cmd_queue;
    localparam int AW      = 10;
    localparam int DW      = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;

    logic PCLK = 1'b0;
    logic PRESET;
    int   checks = 0;
    int   errors = 0;

    apb_cmd_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    apb_cmd_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && k < 50) begin
            step();
            k++;
        end
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Waits for the issue pulse, checks the request, then completes it with xfer_done.
    task automatic serve(input string tag, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int k = 0;
        while (!bus.transfer && k < 20) begin
            step();
            k++;
        end
        check({tag, "_issue"}, 32'(bus.transfer), 32'd1);
        check({tag, "_addr"}, 32'(bus.in_addr), 32'(a));
        check({tag, "_rw"}, 32'(bus.READ_WRITE), 32'(wr));
        if (wr) check({tag, "_wdata"}, 32'(bus.in_wr_data), 32'(d));
        step();
        check({tag, "_wait_no_pulse"}, 32'(bus.transfer), 32'd0);
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0;
    endtask

    initial begin
        PRESET          = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = 1'b1;
        bus.cmd_addr    = 10'h0AA;
        bus.cmd_wdata   = 16'h5555;
        bus.out_rd_data = '0;
        bus.xfer_done   = 1'b0;
        bus.rsp_ready   = 1'b0;

        // 1: reset with cmd_valid asserted
        step();
        step();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_transfer", 32'(bus.transfer), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_addr", 32'(bus.in_addr), 32'd0);
        check("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        PRESET        = 1'b0;
        bus.cmd_valid = 1'b0;
        step();
        check("rst_no_push", 32'(bus.level), 32'd0);
        check("rst_no_issue", 32'(bus.transfer), 32'd0);

        // 2: single write, accepted at N
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 10'h005;
        bus.cmd_wdata = 16'hA5A5;
        step();
        bus.cmd_valid = 1'b0;
        check("wr_n1_transfer", 32'(bus.transfer), 32'd0);
        check("wr_n1_level", 32'(bus.level), 32'd1);
        step();
        check("wr_n2_transfer", 32'(bus.transfer), 32'd1);
        check("wr_n2_addr", 32'(bus.in_addr), 32'h005);
        check("wr_n2_rw", 32'(bus.READ_WRITE), 32'd1);
        check("wr_n2_wdata", 32'(bus.in_wr_data), 32'hA5A5);
        step();
        check("wr_n3_transfer", 32'(bus.transfer), 32'd0);
        check("wr_n3_addr", 32'(bus.in_addr), 32'h005);
        step();
        bus.xfer_done = 1'b1;
        check("wr_n4_transfer", 32'(bus.transfer), 32'd0);
        check("wr_n4_rw", 32'(bus.READ_WRITE), 32'd1);
        check("wr_n4_busy", 32'(bus.busy), 32'd1);
        step();
        bus.xfer_done = 1'b0;
        check("wr_n5_busy", 32'(bus.busy), 32'd0);
        check("wr_n5_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // 3: single read, xfer_done at M, data presented at M+1
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h205;
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("rd_issue", 32'(bus.transfer), 32'd1);
        check("rd_addr", 32'(bus.in_addr), 32'h205);
        check("rd_rw", 32'(bus.READ_WRITE), 32'd0);
        step();
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done   = 1'b0;
        bus.out_rd_data = 16'h1234;
        check("rd_m1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        bus.out_rd_data = 16'hFFFF;
        check("rd_m2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_m2_rsp_data", 32'(bus.rsp_data), 32'h1234);
        check("rd_m2_rsp_err", 32'(bus.rsp_err), 32'd0);
        step();
        step();
        check("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_hold_data", 32'(bus.rsp_data), 32'h1234);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rd_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("rd_idle", 32'(bus.busy), 32'd0);

        // 4: fill to full (first write is issued and parked in WAIT), then drain and refill
        for (int round = 0; round < 2; round++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b1;
            for (int i = 0; i < 9; i++) begin
                bus.cmd_addr  = AW'(16 * (round + 1) + i);
                bus.cmd_wdata = DW'(4096 * (round + 1) + i);
                check("fill_ready", 32'(bus.cmd_ready), 32'd1);
                step();
            end
            bus.cmd_addr  = 10'h3FF;
            bus.cmd_wdata = 16'hDEAD;
            check("full_level", 32'(bus.level), 32'd8);
            check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
            bus.cmd_valid = 1'b0;
            check("full_no_push", 32'(bus.level), 32'd8);
            check("full_head_addr", 32'(bus.in_addr), 32'(16 * (round + 1)));
            bus.xfer_done = 1'b1;
            step();
            bus.xfer_done = 1'b0;
            for (int i = 1; i < 9; i++)
                serve("drain", 1'b1, AW'(16 * (round + 1) + i), DW'(4096 * (round + 1) + i));
            check("drained_level", 32'(bus.level), 32'd0);
            check("drained_busy", 32'(bus.busy), 32'd0);
        end

        // 5: second read held back by an unconsumed response
        push(1'b0, 10'h201, '0);
        push(1'b0, 10'h202, '0);
        serve("rd1", 1'b0, 10'h201, '0);
        bus.out_rd_data = 16'hBEEF;
        step();
        check("rd1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd1_rsp_data", 32'(bus.rsp_data), 32'hBEEF);
        for (int i = 0; i < 4; i++) begin
            check("stall_no_transfer", 32'(bus.transfer), 32'd0);
            check("stall_level", 32'(bus.level), 32'd1);
            bus.xfer_done = (i == 1);
            step();
        end
        bus.xfer_done = 1'b0;
        check("stall_data_held", 32'(bus.rsp_data), 32'hBEEF);
        check("stall_still_no_transfer", 32'(bus.transfer), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rd2_issue_after_hs", 32'(bus.transfer), 32'd1);
        check("rd2_addr", 32'(bus.in_addr), 32'h202);
        check("rd2_slot_cleared", 32'(bus.rsp_valid), 32'd0);
        check("rd2_level", 32'(bus.level), 32'd0);
        step();
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done   = 1'b0;
        bus.out_rd_data = 16'h5A5A;
        step();
        check("rd2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd2_rsp_data", 32'(bus.rsp_data), 32'h5A5A);
        check("rd2_rsp_err", 32'(bus.rsp_err), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rd2_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("rd2_idle", 32'(bus.busy), 32'd0);

`ifdef APB_CMD_QUEUE_TIMEOUT_EN
        // 6: read never completes; abort after TIMEOUT WAIT cycles, queued write follows
        push(1'b0, 10'h300, '0);
        push(1'b1, 10'h301, 16'hC3C3);
        check("to_issue", 32'(bus.transfer), 32'd1);
        check("to_addr", 32'(bus.in_addr), 32'h300);
        for (int i = 0; i < TIMEOUT; i++) step();
        check("to_not_yet", 32'(bus.err_timeout), 32'd0);
        check("to_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
        step();
        check("to_pulse", 32'(bus.err_timeout), 32'd1);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("to_rsp_data", 32'(bus.rsp_data), 32'd0);
        step();
        check("to_pulse_end", 32'(bus.err_timeout), 32'd0);
        check("to_next_issue", 32'(bus.transfer), 32'd1);
        check("to_next_addr", 32'(bus.in_addr), 32'h301);
        check("to_next_rw", 32'(bus.READ_WRITE), 32'd1);
        step();
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("to_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("to_idle", 32'(bus.busy), 32'd0);
`else
        check("no_timeout_err", 32'(bus.err_timeout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
